mac_dot_sequencer: RTL and testbench

//  Sequences the combinational 32x32 MAC datapath (`mac`) over a streamed vector
//  of operand pairs and produces an unsigned dot product.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac.sv | 14 +
 rtl/mac_dot_sequencer.sv | 103 ++++++++++
 tb/tb_mac_dot_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
package mac_pkg;

  localparam int unsigned OP_W  = 32;
  localparam int unsigned ACC_W = 64;
  localparam int unsigned MAC_W = ACC_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Accumulator state: running sum plus sticky carry-out flag.
  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] sum;
  } acc_state_t;

endpackage

// File: rtl/mac.sv
// Combinational unsigned multiply-accumulate: sum = a*b + c, full 65-bit result.
module mac
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [ACC_W-1:0] c,
  output logic [MAC_W-1:0] sum
);

  // Product fits in 64 bits; the extra bit captures the accumulate carry.
  assign sum = MAC_W'(a) * MAC_W'(b) + MAC_W'(c);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Streams operand pairs through the MAC and returns an unsigned dot product.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             chain,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_acc,
  output logic             res_ovf,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  acc_state_t       acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [MAC_W-1:0] mac_sum;

  // Datapath: current operands added onto the running sum.
  mac u_mac (
    .a   (op_a),
    .b   (op_b),
    .c   (acc_q.sum),
    .sum (mac_sum)
  );

  // State, accumulator, beat counter and captured length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and datapath update; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!chain) begin
              acc_d = '0;
            end
            cnt_d   = '0;
            len_d   = len;
            state_d = (len != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (op_valid) begin
            acc_d.sum = mac_sum[ACC_W-1:0];
            acc_d.ovf = acc_q.ovf | mac_sum[MAC_W-1];
            cnt_d     = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status decode from the state register; abort withholds the ack.
  assign op_ready  = (state_q == ST_RUN) && !abort;
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign res_acc   = acc_q.sum;
  assign res_ovf   = acc_q.ovf;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed self-checking bench for mac_dot_sequencer.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        chain;
  logic [15:0] len;
  logic        abort;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_acc;
  logic        res_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mac_dot_sequencer #(.LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .chain     (chain),
    .len       (len),
    .abort     (abort),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_acc   (res_acc),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start command.
  task automatic do_start(input logic ch, input logic [15:0] n);
    start = 1'b1;
    chain = ch;
    len   = n;
    tick();
    start = 1'b0;
    chain = 1'b0;
  endtask

  // Present one operand pair for a single cycle.
  task automatic feed(input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid.
  task automatic wait_res(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Consume the result and return to IDLE.
  task automatic pop_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({op_ready, res_valid, busy, res_ovf} !== 4'b0 || res_acc !== 64'd0) begin
      errors++;
      $display("FAIL reset_init: rdy=%b rv=%b busy=%b ovf=%b acc=%h, want all 0",
               op_ready, res_valid, busy, res_ovf, res_acc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Reset in the middle of a run discards the partial sum.
    do_start(1'b0, 16'd3);
    feed(32'd9, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({op_ready, res_valid, busy, res_ovf} !== 4'b0 || res_acc !== 64'd0) begin
      errors++;
      $display("FAIL reset_midrun: rdy=%b rv=%b busy=%b ovf=%b acc=%h, want all 0",
               op_ready, res_valid, busy, res_ovf, res_acc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    do_start(1'b0, 16'd3);
    checks++;
    if (busy !== 1'b1 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_run: busy=%b rdy=%b want 1 1", busy, op_ready);
    end
    feed(32'd2, 32'd3);
    feed(32'd4, 32'd5);
    checks++;
    if (res_valid !== 1'b0 || res_acc !== 64'd26) begin
      errors++;
      $display("FAIL basic_partial: rv=%b acc=%0d want 0 26", res_valid, res_acc);
    end
    feed(32'd6, 32'd7);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 64'd68 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: rv=%b acc=%0d ovf=%b want 1 68 0", res_valid, res_acc, res_ovf);
    end
    pop_result();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: rv=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_chain();
    bit seen;
    do_start(1'b1, 16'd1);
    feed(32'd10, 32'd10);
    wait_res(seen);
    checks++;
    if (!seen || res_acc !== 64'd168 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL chain_result: seen=%b acc=%0d ovf=%b want 1 168 0", seen, res_acc, res_ovf);
    end
    pop_result();
  endtask

  task automatic test_backpressure();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    int idx;
    int beats;
    va = '{32'd2, 32'd4, 32'd6};
    vb = '{32'd3, 32'd5, 32'd7};
    idx   = 0;
    beats = 0;
    do_start(1'b0, 16'd3);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (res_valid) break;
      op_valid = (cyc % 3 == 0);
      op_a     = (idx < 3) ? va[idx] : 32'd0;
      op_b     = (idx < 3) ? vb[idx] : 32'd0;
      if (op_valid && op_ready) begin
        beats++;
        idx++;
      end
      tick();
    end
    op_valid = 1'b1;
    op_a     = 32'd100;
    op_b     = 32'd100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_acc !== 64'd68 || op_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b acc=%0d rdy=%b want 1 68 0", i, res_valid, res_acc, op_ready);
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if (beats !== 3) begin
      errors++;
      $display("FAIL bp_beats: got %0d want 3", beats);
    end
    pop_result();
    checks++;
    if (busy !== 1'b0 || res_acc !== 64'd68) begin
      errors++;
      $display("FAIL bp_pop: busy=%b acc=%0d want 0 68", busy, res_acc);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    // (2^32-1)^2 = 0xFFFFFFFE00000001; adding it twice carries out of bit 63.
    do_start(1'b0, 16'd2);
    feed(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (res_acc !== 64'hFFFF_FFFE_0000_0001 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: acc=%h ovf=%b want fffffffe00000001 0", res_acc, res_ovf);
    end
    feed(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_res(seen);
    checks++;
    if (!seen || res_acc !== 64'hFFFF_FFFC_0000_0002 || res_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_len2: seen=%b acc=%h ovf=%b want 1 fffffffc00000002 1", seen, res_acc, res_ovf);
    end
    pop_result();
    do_start(1'b1, 16'd4);
    for (int i = 0; i < 4; i++) feed(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_res(seen);
    checks++;
    if (!seen || res_acc !== 64'hFFFF_FFF4_0000_0006 || res_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_chain4: seen=%b acc=%h ovf=%b want 1 fffffff400000006 1", seen, res_acc, res_ovf);
    end
    pop_result();
    // A carry-free chained beat must leave the flag set.
    do_start(1'b1, 16'd1);
    feed(32'd0, 32'd0);
    wait_res(seen);
    checks++;
    if (!seen || res_acc !== 64'hFFFF_FFF4_0000_0006 || res_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: seen=%b acc=%h ovf=%b want 1 fffffff400000006 1", seen, res_acc, res_ovf);
    end
    pop_result();
  endtask

  task automatic test_edge();
    bit seen;
    // Zero length goes straight to DONE with a cleared accumulator.
    do_start(1'b0, 16'd0);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 64'd0 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL len0: rv=%b acc=%h ovf=%b want 1 0 0", res_valid, res_acc, res_ovf);
    end
    // Pop with a coincident start: start ignored, IDLE next.
    res_ready = 1'b1;
    start     = 1'b1;
    len       = 16'd2;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: busy=%b want 0", busy);
    end
    // Abort mid-run with a valid operand pending.
    do_start(1'b0, 16'd3);
    feed(32'd5, 32'd5);
    // Start during RUN must not restart or shorten the run.
    start = 1'b1;
    len   = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0 || res_acc !== 64'd25) begin
      errors++;
      $display("FAIL run_start_ignored: busy=%b rv=%b acc=%0d want 1 0 25", busy, res_valid, res_acc);
    end
    op_valid = 1'b1;
    op_a     = 32'd7;
    op_b     = 32'd7;
    abort    = 1'b1;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_rdy: rdy=%b want 0", op_ready);
    end
    tick();
    abort    = 1'b0;
    op_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_acc !== 64'd25 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b acc=%0d rv=%b want 0 25 0", busy, res_acc, res_valid);
    end
    // Counter was cleared by abort: a chained single beat completes at once.
    do_start(1'b1, 16'd1);
    feed(32'd1, 32'd1);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 64'd26) begin
      errors++;
      $display("FAIL abort_cnt: rv=%b acc=%0d want 1 26", res_valid, res_acc);
    end
    pop_result();
    wait_res(seen);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL idle_no_result: res_valid=%b want 0", res_valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    chain     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_chain();
    test_backpressure();
    test_overflow();
    test_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
